// File: rtl/z80fi_ixiy_mem_checker.sv
// Checks indexed (IX/IY + d) loads and stores in a retired-instruction stream against a small shadow memory.
// Define Z80FI_SIGNED_DISP_EN to sign-extend the displacement; by default it is zero-extended.
module z80fi_ixiy_mem_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             z80fi_valid,
  input  logic [31:0]      z80fi_insn,
  input  logic [2:0]       z80fi_insn_len,
  input  logic [15:0]      z80fi_reg1_rdata,
  input  logic [15:0]      z80fi_reg2_rdata,
  input  logic [15:0]      z80fi_mem_raddr,
  input  logic [7:0]       z80fi_mem_rdata,
  input  logic [15:0]      z80fi_mem_waddr,
  input  logic [7:0]       z80fi_mem_wdata,
  output logic             chk_fail,
  output logic [1:0]       chk_code,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]      r_addr [DEPTH];
  logic [7:0]       r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_ptr;
  logic             r_chk_fail;
  logic [1:0]       r_chk_code;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_indexed;
  logic             w_load;
  logic             w_store;
  logic [15:0]      w_disp;
  logic [15:0]      w_ea;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  logic [7:0]       w_hit_data;
  logic             w_addr_err;
  logic             w_data_err;
  logic             w_fail;
  logic             w_unused_bits;

  assign w_unused_bits = ^{z80fi_insn[31:24], z80fi_reg2_rdata[15:8]};

  assign w_indexed = z80fi_valid && (z80fi_insn_len == 3'd3) &&
                     ((z80fi_insn[7:0] == 8'hDD) || (z80fi_insn[7:0] == 8'hFD));
  assign w_load    = w_indexed && (z80fi_insn[15:14] == 2'b01) &&
                     (z80fi_insn[10:8] == 3'b110) && (z80fi_insn[13:11] != 3'b110);
  assign w_store   = w_indexed && (z80fi_insn[15:11] == 5'b01110) &&
                     (z80fi_insn[10:8] != 3'b110);

`ifdef Z80FI_SIGNED_DISP_EN
  assign w_disp = {{8{z80fi_insn[23]}}, z80fi_insn[23:16]};
`else
  assign w_disp = {8'h00, z80fi_insn[23:16]};
`endif
  assign w_ea = z80fi_reg1_rdata + w_disp;

  // Scan high-to-low so the lowest-index hit is the one that sticks.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_hit_data = 8'h00;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_addr[i] == w_ea)) begin
        w_hit      = 1'b1;
        w_hit_idx  = PTR_W'(i);
        w_hit_data = r_data[i];
      end
    end
  end

  assign w_addr_err = (w_load && (z80fi_mem_raddr != w_ea)) ||
                      (w_store && ((z80fi_mem_waddr != w_ea) ||
                                   (z80fi_mem_wdata != z80fi_reg2_rdata[7:0])));
  assign w_data_err = w_load && w_hit && (z80fi_mem_rdata != w_hit_data);
  assign w_fail     = w_addr_err || w_data_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_fail  <= 1'b0;
      r_chk_code  <= 2'b00;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_hit_cnt   <= '0;
    end else begin
      r_chk_fail <= w_fail;
      if (w_fail) r_chk_code <= {w_data_err, w_addr_err};
      if (w_load && (r_load_cnt != '1)) r_load_cnt <= r_load_cnt + 1'b1;
      if (w_store && (r_store_cnt != '1)) r_store_cnt <= r_store_cnt + 1'b1;
      if (w_load && w_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  // A record coinciding with flush is still checked above but must not touch the table.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_store && !w_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (PTR_W'(i) == r_ptr) r_valid[i] <= 1'b1;
      end
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_store) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit && (PTR_W'(i) == w_hit_idx)) begin
          r_data[i] <= z80fi_mem_wdata;
        end else if (!w_hit && (PTR_W'(i) == r_ptr)) begin
          r_addr[i] <= w_ea;
          r_data[i] <= z80fi_mem_wdata;
        end
      end
    end
  end

  assign chk_fail  = r_chk_fail;
  assign chk_code  = r_chk_code;
  assign load_cnt  = r_load_cnt;
  assign store_cnt = r_store_cnt;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_z80fi_ixiy_mem_checker.sv
// Directed bench for z80fi_ixiy_mem_checker; a second narrow instance exercises counter saturation.
// Expectations for the displacement case follow Z80FI_SIGNED_DISP_EN.
module tb_z80fi_ixiy_mem_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        z80fi_valid = 1'b0;
  logic [31:0] z80fi_insn = '0;
  logic [2:0]  z80fi_insn_len = '0;
  logic [15:0] z80fi_reg1_rdata = '0;
  logic [15:0] z80fi_reg2_rdata = '0;
  logic [15:0] z80fi_mem_raddr = '0;
  logic [7:0]  z80fi_mem_rdata = '0;
  logic [15:0] z80fi_mem_waddr = '0;
  logic [7:0]  z80fi_mem_wdata = '0;

  logic        chk_fail;
  logic [1:0]  chk_code;
  logic [15:0] load_cnt, store_cnt, hit_cnt;
  logic        s_chk_fail;
  logic [1:0]  s_chk_code;
  logic [1:0]  s_load_cnt, s_store_cnt, s_hit_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  z80fi_ixiy_mem_checker #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .z80fi_valid(z80fi_valid),
    .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg1_rdata(z80fi_reg1_rdata), .z80fi_reg2_rdata(z80fi_reg2_rdata),
    .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
    .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
    .chk_fail(chk_fail), .chk_code(chk_code),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .hit_cnt(hit_cnt)
  );

  z80fi_ixiy_mem_checker #(.DEPTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .z80fi_valid(z80fi_valid),
    .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg1_rdata(z80fi_reg1_rdata), .z80fi_reg2_rdata(z80fi_reg2_rdata),
    .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
    .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
    .chk_fail(s_chk_fail), .chk_code(s_chk_code),
    .load_cnt(s_load_cnt), .store_cnt(s_store_cnt), .hit_cnt(s_hit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] pfx, input logic [7:0] op, input logic [7:0] d,
                      input logic [2:0] len, input logic [15:0] r1, input logic [15:0] r2,
                      input logic [15:0] ra, input logic [7:0] rd,
                      input logic [15:0] wa, input logic [7:0] wd,
                      input logic vld, input logic fl);
    z80fi_valid      = vld;
    flush            = fl;
    z80fi_insn       = {8'h00, d, op, pfx};
    z80fi_insn_len   = len;
    z80fi_reg1_rdata = r1;
    z80fi_reg2_rdata = r2;
    z80fi_mem_raddr  = ra;
    z80fi_mem_rdata  = rd;
    z80fi_mem_waddr  = wa;
    z80fi_mem_wdata  = wd;
    @(posedge clk);
    #1;
    z80fi_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic st(input logic [7:0] pfx, input logic [7:0] d, input logic [15:0] r1,
                    input logic [15:0] r2, input logic [15:0] wa, input logic [7:0] wd,
                    input logic fl);
    send(pfx, 8'h77, d, 3'd3, r1, r2, 16'h0000, 8'h00, wa, wd, 1'b1, fl);
  endtask

  task automatic ld(input logic [7:0] pfx, input logic [7:0] op, input logic [7:0] d,
                    input logic [15:0] r1, input logic [15:0] ra, input logic [7:0] rd);
    send(pfx, op, d, 3'd3, r1, 16'h0000, ra, rd, 16'h0000, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_disp_code;
    logic       exp_disp_fail;
`ifdef Z80FI_SIGNED_DISP_EN
    exp_disp_fail = 1'b0;
    exp_disp_code = 2'd2;
`else
    exp_disp_fail = 1'b1;
    exp_disp_code = 2'd1;
`endif

    reset = 1'b1;
    idle();
    idle();
    chk("rst_fail", chk_fail, 0);
    chk("rst_code", chk_code, 0);
    chk("rst_ld", load_cnt, 0);
    chk("rst_st", store_cnt, 0);
    chk("rst_hit", hit_cnt, 0);
    reset = 1'b0;
    idle();

    // store then matching load hits
    st(8'hDD, 8'h05, 16'h2000, 16'h00AB, 16'h2005, 8'hAB, 1'b0);
    chk("st1_fail", chk_fail, 0);
    chk("st1_cnt", store_cnt, 1);
    ld(8'hDD, 8'h7E, 8'h05, 16'h2000, 16'h2005, 8'hAB);
    chk("ld1_fail", chk_fail, 0);
    chk("ld1_cnt", load_cnt, 1);
    chk("ld1_hit", hit_cnt, 1);

    // load with wrong data
    ld(8'hDD, 8'h7E, 8'h05, 16'h2000, 16'h2005, 8'hAC);
    chk("ld2_fail", chk_fail, 1);
    chk("ld2_code", chk_code, 2);
    chk("ld2_hit", hit_cnt, 2);
    idle();
    chk("pulse_end", chk_fail, 0);
    chk("code_hold", chk_code, 2);

    // IY + d wraps past 0xFFFF
    ld(8'hFD, 8'h46, 8'h10, 16'hFFF8, 16'h0008, 8'h33);
    chk("wrap_fail", chk_fail, 0);
    chk("wrap_hit", hit_cnt, 2);
    chk("wrap_cnt", load_cnt, 3);

    // wrong address and wrong data together
    ld(8'hDD, 8'h7E, 8'h05, 16'h2000, 16'h2006, 8'hAC);
    chk("both_fail", chk_fail, 1);
    chk("both_code", chk_code, 3);
    chk("both_hit", hit_cnt, 3);

    // store whose data differs from source register
    st(8'hDD, 8'h06, 16'h2000, 16'h0011, 16'h2006, 8'h12, 1'b0);
    chk("stbad_fail", chk_fail, 1);
    chk("stbad_code", chk_code, 1);

    // store hit overwrites, immediate load sees it
    st(8'hDD, 8'h05, 16'h2000, 16'h005A, 16'h2005, 8'h5A, 1'b0);
    chk("ovw_fail", chk_fail, 0);
    ld(8'hDD, 8'h7E, 8'h05, 16'h2000, 16'h2005, 8'h5A);
    chk("ovw_ld_fail", chk_fail, 0);
    chk("ovw_hit", hit_cnt, 4);
    chk("ovw_ldcnt", load_cnt, 5);
    chk("ovw_stcnt", store_cnt, 3);

    // flush with concurrent store: counted, not written
    st(8'hDD, 8'h00, 16'h3000, 16'h0077, 16'h3000, 8'h77, 1'b1);
    chk("fl_stcnt", store_cnt, 4);
    ld(8'hDD, 8'h7E, 8'h00, 16'h3000, 16'h3000, 8'h00);
    chk("fl_ld_fail", chk_fail, 0);
    chk("fl_ld_hit", hit_cnt, 4);
    ld(8'hDD, 8'h7E, 8'h05, 16'h2000, 16'h2005, 8'h00);
    chk("fl_old_fail", chk_fail, 0);
    chk("fl_old_hit", hit_cnt, 4);

    // five stores into four entries evict 0x100
    for (int i = 0; i < 5; i++) begin
      st(8'hDD, 8'(i), 16'h0100, 16'(8'h40 + i), 16'(16'h0100 + i), 8'(8'h40 + i), 1'b0);
    end
    chk("ev_stcnt", store_cnt, 9);
    ld(8'hDD, 8'h7E, 8'h00, 16'h0100, 16'h0100, 8'hFF);
    chk("ev_miss_fail", chk_fail, 0);
    chk("ev_miss_hit", hit_cnt, 4);
    ld(8'hDD, 8'h7E, 8'h04, 16'h0100, 16'h0104, 8'h44);
    chk("ev_hit_fail", chk_fail, 0);
    chk("ev_hit_cnt", hit_cnt, 5);
    ld(8'hDD, 8'h7E, 8'h02, 16'h0100, 16'h0102, 8'h40);
    chk("ev_e2_fail", chk_fail, 1);
    chk("ev_e2_code", chk_code, 2);
    chk("ev_e2_hit", hit_cnt, 6);

    // displacement extension
    ld(8'hDD, 8'h7E, 8'hFE, 16'h1000, 16'h0FFE, 8'h00);
    chk("disp_fail", chk_fail, 32'(exp_disp_fail));
    chk("disp_code", chk_code, 32'(exp_disp_code));
    chk("disp_ldcnt", load_cnt, 11);

    // non-matching length and invalid record change nothing
    send(8'hDD, 8'h7E, 8'h00, 3'd2, 16'h2000, 16'h0000, 16'hDEAD, 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0);
    chk("len2_fail", chk_fail, 0);
    chk("len2_cnt", load_cnt, 11);
    send(8'hDD, 8'h7E, 8'h00, 3'd3, 16'h2000, 16'h0000, 16'hDEAD, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    chk("inv_fail", chk_fail, 0);
    chk("inv_cnt", load_cnt, 11);
    chk("inv_code", chk_code, 32'(exp_disp_code));

    // narrow instance counters saturate at 3
    chk("sat_ld", s_load_cnt, 3);
    chk("sat_st", s_store_cnt, 3);
    chk("sat_hit", s_hit_cnt, 3);

    // reset mid-stream, coinciding with a failing record
    reset = 1'b1;
    ld(8'hDD, 8'h7E, 8'h04, 16'h0100, 16'hBEEF, 8'h00);
    reset = 1'b0;
    chk("mrst_fail", chk_fail, 0);
    chk("mrst_code", chk_code, 0);
    chk("mrst_ld", load_cnt, 0);
    chk("mrst_st", store_cnt, 0);
    chk("mrst_hit", hit_cnt, 0);
    ld(8'hDD, 8'h7E, 8'h04, 16'h0100, 16'h0104, 8'h00);
    chk("post_fail", chk_fail, 0);
    chk("post_hit", hit_cnt, 0);
    chk("post_ld", load_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/z80fi_ixiy_mem_checker.md
Z80FI_IXIY_MEM_CHECKER -- requirements
Module: z80fi_ixiy_mem_checker

Interface
REQ-001 Parameter DEPTH, default 4, number of shadow-memory entries; legal range 1..16.
REQ-002 Parameter CNT_W, default 16, width of each event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  invalidates all shadow entries.
REQ-006 z80fi_valid  input  1  one retired-instruction record is present this cycle.
REQ-007 z80fi_insn  input  32  instruction bytes; first opcode byte in [7:0].
REQ-008 z80fi_insn_len  input  3  instruction length in bytes.
REQ-009 z80fi_reg1_rdata  input  16  IX or IY value read by the instruction.
REQ-010 z80fi_reg2_rdata  input  16  source register value; the low byte is used.
REQ-011 z80fi_mem_raddr / z80fi_mem_rdata  input  16 / 8  memory read address and data.
REQ-012 z80fi_mem_waddr / z80fi_mem_wdata  input  16 / 8  memory write address and data.
REQ-013 chk_fail  output  1  registered one-cycle pulse when a check fails.
REQ-014 chk_code  output  2  failure cause: 1 = address mismatch, 2 = data mismatch, 3 = both; held until the next failure.
REQ-015 load_cnt / store_cnt / hit_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 A load SHALL be decoded when valid, len==3, insn[7:0] is 0xDD or 0xFD, insn[15:14]==01, insn[10:8]==110, and insn[13:11]!=110.
REQ-017 A store SHALL be decoded when valid, len==3, insn[7:0] is 0xDD or 0xFD, insn[15:11]==01110, and insn[10:8]!=110.
REQ-018 The effective address SHALL be z80fi_reg1_rdata + ext(insn[23:16]), computed mod 2^16; ext is defined under Configuration.
REQ-019 Load: if raddr != effective address, an address mismatch SHALL be flagged.
REQ-020 Load: on a shadow hit (a valid entry whose address equals the effective address), data mismatch SHALL be flagged when mem_rdata != the entry data; hit_cnt SHALL increment.
REQ-021 Store: if waddr != effective address or wdata != reg2_rdata[7:0], an address mismatch SHALL be flagged.
REQ-022 Store with a hit SHALL overwrite that entry's data; a miss SHALL allocate the entry at the round-robin pointer (data = wdata, valid = 1), and the pointer SHALL advance.
REQ-023 The allocation pointer SHALL wrap from DEPTH-1 to 0; a full table SHALL evict the oldest-allocated entry.
REQ-024 Shadow updates SHALL become visible on the cycle after the store; a load on the immediately next record SHALL see them.
REQ-025 chk_fail and chk_code SHALL update one cycle after the offending record (latency 1).
REQ-026 load_cnt and store_cnt SHALL increment per decoded load or store; every counter SHALL saturate at all-ones.
REQ-027 flush SHALL clear all valid bits and the pointer; a record in the same cycle SHALL be checked against the pre-flush table and counted, but SHALL NOT write the shadow.
REQ-028 Non-matching or invalid records SHALL change no state.
REQ-029 Duplicate-address entries SHALL never exist; the lowest-index hit is authoritative.

Reset
REQ-030 Reset SHALL clear all valid bits, the pointer, all counters, chk_fail and chk_code to 0 on the next edge, including mid-stream; the record in the reset cycle is discarded.
REQ-031 Reset SHALL have priority over flush and over record processing.

Configuration
REQ-032 Macro Z80FI_SIGNED_DISP_EN defined: ext SHALL sign-extend d (IX=0x1000, d=0xFE gives 0x0FFE).
REQ-033 Macro Z80FI_SIGNED_DISP_EN undefined: ext SHALL zero-extend d (IX=0x1000, d=0xFE gives 0x10FE).

Verification
REQ-034 Store DD 77 05 with IX=0x2000, reg2=0x00AB, waddr=0x2005, wdata=0xAB; then load DD 7E 05 with rdata=0xAB -> no chk_fail; store_cnt=1, load_cnt=1, hit_cnt=1.
REQ-035 Same store, then load with rdata=0xAC -> chk_fail pulse one cycle after the load, chk_code=2.
REQ-036 Load FD 46 10 with IY=0xFFF8, raddr=0x0008 -> no failure (address wraps).
REQ-037 With DEPTH=4, stores to 0x100..0x104, then load 0x100 -> no hit (entry evicted), hit_cnt unchanged; load 0x104 -> hit.
REQ-038 Signed build: IX=0x1000, d=0xFE, raddr=0x0FFE -> pass; unsigned build with the same stimulus -> chk_code=1.
REQ-039 Flush concurrent with a store, then load the same address -> no hit; reset asserted mid-stream -> all outputs read 0 on the next cycle.
